// File: rtl/tfe_flow_dispatch.sv
// Ready-flow dispatcher: queues threshold events, offers them round-robin to
// credit-limited PEs, and returns forward/reverse addresses in dispatch order on free.
module tfe_flow_dispatch #(
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned NUM_PE     = 2,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned MAX_INFL   = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        reach_thrh,
    input  logic [ADDR_W-1:0]           i_fea_addr,
    input  logic [ADDR_W-1:0]           i_r_fea_addr,
    output logic [NUM_PE-1:0]           o_disp_v,
    output logic [ADDR_W-1:0]           o_disp_addr,
    input  logic [NUM_PE-1:0]           i_disp_rdy,
    input  logic [NUM_PE-1:0]           i_free,
    output logic [ADDR_W-1:0]           o_free_addr,
    output logic [ADDR_W-1:0]           o_free_r_addr,
    output logic                        o_free_v,
    output logic [$clog2(FIFO_DEPTH):0] o_fifo_cnt,
    output logic [CNT_W-1:0]            o_drop_cnt,
    output logic                        o_free_err
);

    localparam int unsigned QP_W = $clog2(FIFO_DEPTH);
    localparam int unsigned QC_W = QP_W + 1;
    localparam int unsigned IP_W = $clog2(MAX_INFL);
    localparam int unsigned IC_W = IP_W + 1;
    localparam int unsigned PE_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam int unsigned E_W  = 2 * ADDR_W;

    typedef enum logic {IDLE, OFFER} state_e;

    state_e            state_q, state_d;
    logic [QP_W-1:0]   q_wr_q, q_wr_d, q_rd_q, q_rd_d;
    logic [QC_W-1:0]   q_cnt_q, q_cnt_d;
    logic [CNT_W-1:0]  drop_q, drop_d;
    logic [PE_W-1:0]   rr_q, rr_d, gnt_q, gnt_d;
    logic [ADDR_W-1:0] disp_addr_q, disp_addr_d;
    logic [IP_W-1:0]   inf_wr_q [NUM_PE];
    logic [IP_W-1:0]   inf_wr_d [NUM_PE];
    logic [IP_W-1:0]   inf_rd_q [NUM_PE];
    logic [IP_W-1:0]   inf_rd_d [NUM_PE];
    logic [IC_W-1:0]   inf_cnt_q [NUM_PE];
    logic [IC_W-1:0]   inf_cnt_d [NUM_PE];
    logic [IC_W-1:0]   pend_q [NUM_PE];
    logic [IC_W-1:0]   pend_d [NUM_PE];
    logic              free_v_q, free_v_d;
    logic [ADDR_W-1:0] free_addr_q, free_addr_d, free_r_addr_q, free_r_addr_d;
    logic              free_err_q, free_err_d;

    logic [E_W-1:0]    q_mem [FIFO_DEPTH];
    logic [E_W-1:0]    inf_mem [NUM_PE][MAX_INFL];

    logic              push, accept, serve, found;
    logic              dpush, spop, fok;
    logic [PE_W-1:0]   serve_idx;
    logic [E_W-1:0]    serve_data;
    int unsigned       idx;

    always_comb begin
        state_d       = state_q;
        q_wr_d        = q_wr_q;
        q_rd_d        = q_rd_q;
        q_cnt_d       = q_cnt_q;
        drop_d        = drop_q;
        rr_d          = rr_q;
        gnt_d         = gnt_q;
        disp_addr_d   = disp_addr_q;
        inf_wr_d      = inf_wr_q;
        inf_rd_d      = inf_rd_q;
        inf_cnt_d     = inf_cnt_q;
        pend_d        = pend_q;
        free_err_d    = free_err_q;
        free_addr_d   = free_addr_q;
        free_r_addr_d = free_r_addr_q;
        o_disp_v      = '0;
        found         = 1'b0;
        serve         = 1'b0;
        serve_idx     = '0;
        serve_data    = '0;
        dpush         = 1'b0;
        spop          = 1'b0;
        fok           = 1'b0;
        idx           = 0;

        // Full check uses the pre-pop count: a push at full is dropped even while popping.
        push   = reach_thrh && (q_cnt_q < QC_W'(FIFO_DEPTH));
        accept = (state_q == OFFER) && i_disp_rdy[gnt_q];

        if (push) begin
            q_wr_d = q_wr_q + QP_W'(1);
        end else if (reach_thrh && (drop_q != '1)) begin
            drop_d = drop_q + CNT_W'(1);
        end
        if (accept) begin
            q_rd_d = q_rd_q + QP_W'(1);
        end
        if (push && !accept) begin
            q_cnt_d = q_cnt_q + QC_W'(1);
        end else if (!push && accept) begin
            q_cnt_d = q_cnt_q - QC_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (q_cnt_q != '0) begin
                    for (int unsigned i = 0; i < NUM_PE; i++) begin
                        idx = (int'(rr_q) + i) % NUM_PE;
                        if (!found && (inf_cnt_q[idx] < IC_W'(MAX_INFL))) begin
                            found = 1'b1;
                            gnt_d = PE_W'(idx);
                        end
                    end
                    if (found) begin
                        state_d     = OFFER;
                        disp_addr_d = q_mem[q_rd_q][E_W-1:ADDR_W];
                    end
                end
            end
            OFFER: begin
                o_disp_v[gnt_q] = 1'b1;
                if (accept) begin
                    state_d = IDLE;
                    rr_d    = PE_W'((int'(gnt_q) + 1) % NUM_PE);
                end
            end
            default: state_d = IDLE;
        endcase

        for (int unsigned k = 0; k < NUM_PE; k++) begin
            if (!serve && (pend_q[k] != '0)) begin
                serve     = 1'b1;
                serve_idx = PE_W'(k);
            end
        end
        if (serve) begin
            serve_data    = inf_mem[serve_idx][inf_rd_q[serve_idx]];
            free_addr_d   = serve_data[E_W-1:ADDR_W];
            free_r_addr_d = serve_data[ADDR_W-1:0];
        end
        free_v_d = serve;

        for (int unsigned k = 0; k < NUM_PE; k++) begin
            dpush = accept && (gnt_q == PE_W'(k));
            spop  = serve && (serve_idx == PE_W'(k));
            fok   = i_free[k] && (inf_cnt_q[k] != pend_q[k]);
            if (dpush) inf_wr_d[k] = inf_wr_q[k] + IP_W'(1);
            if (spop)  inf_rd_d[k] = inf_rd_q[k] + IP_W'(1);
            if (dpush && !spop) begin
                inf_cnt_d[k] = inf_cnt_q[k] + IC_W'(1);
            end else if (!dpush && spop) begin
                inf_cnt_d[k] = inf_cnt_q[k] - IC_W'(1);
            end
            if (fok && !spop) begin
                pend_d[k] = pend_q[k] + IC_W'(1);
            end else if (!fok && spop) begin
                pend_d[k] = pend_q[k] - IC_W'(1);
            end
            if (i_free[k] && !fok) free_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            q_wr_q        <= '0;
            q_rd_q        <= '0;
            q_cnt_q       <= '0;
            drop_q        <= '0;
            rr_q          <= '0;
            gnt_q         <= '0;
            disp_addr_q   <= '0;
            free_v_q      <= 1'b0;
            free_addr_q   <= '0;
            free_r_addr_q <= '0;
            free_err_q    <= 1'b0;
            for (int unsigned k = 0; k < NUM_PE; k++) begin
                inf_wr_q[k]  <= '0;
                inf_rd_q[k]  <= '0;
                inf_cnt_q[k] <= '0;
                pend_q[k]    <= '0;
            end
        end else begin
            state_q       <= state_d;
            q_wr_q        <= q_wr_d;
            q_rd_q        <= q_rd_d;
            q_cnt_q       <= q_cnt_d;
            drop_q        <= drop_d;
            rr_q          <= rr_d;
            gnt_q         <= gnt_d;
            disp_addr_q   <= disp_addr_d;
            free_v_q      <= free_v_d;
            free_addr_q   <= free_addr_d;
            free_r_addr_q <= free_r_addr_d;
            free_err_q    <= free_err_d;
            inf_wr_q      <= inf_wr_d;
            inf_rd_q      <= inf_rd_d;
            inf_cnt_q     <= inf_cnt_d;
            pend_q        <= pend_d;
        end
    end

    // Storage arrays carry no reset; occupancy counters guard every read.
    always_ff @(posedge clk) begin
        if (push) q_mem[q_wr_q] <= {i_fea_addr, i_r_fea_addr};
        if (accept) inf_mem[gnt_q][inf_wr_q[gnt_q]] <= q_mem[q_rd_q];
    end

    assign o_disp_addr   = disp_addr_q;
    assign o_free_v      = free_v_q;
    assign o_free_addr   = free_addr_q;
    assign o_free_r_addr = free_r_addr_q;
    assign o_fifo_cnt    = q_cnt_q;
    assign o_drop_cnt    = drop_q;
    assign o_free_err    = free_err_q;

endmodule

// File: tb/tb_tfe_flow_dispatch.sv
// Directed bench for tfe_flow_dispatch: inputs driven and outputs sampled on the
// falling edge, expected values hand-derived per scenario.
module tb_tfe_flow_dispatch;

    logic        clk;
    logic        rst;
    logic        reach_thrh;
    logic [11:0] i_fea_addr;
    logic [11:0] i_r_fea_addr;
    logic [1:0]  o_disp_v;
    logic [11:0] o_disp_addr;
    logic [1:0]  i_disp_rdy;
    logic [1:0]  i_free;
    logic [11:0] o_free_addr;
    logic [11:0] o_free_r_addr;
    logic        o_free_v;
    logic [4:0]  o_fifo_cnt;
    logic [15:0] o_drop_cnt;
    logic        o_free_err;

    int errors = 0;
    int checks = 0;

    tfe_flow_dispatch #(
        .ADDR_W(12), .NUM_PE(2), .FIFO_DEPTH(16), .MAX_INFL(4), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .reach_thrh(reach_thrh),
        .i_fea_addr(i_fea_addr), .i_r_fea_addr(i_r_fea_addr),
        .o_disp_v(o_disp_v), .o_disp_addr(o_disp_addr), .i_disp_rdy(i_disp_rdy),
        .i_free(i_free), .o_free_addr(o_free_addr), .o_free_r_addr(o_free_r_addr),
        .o_free_v(o_free_v), .o_fifo_cnt(o_fifo_cnt), .o_drop_cnt(o_drop_cnt),
        .o_free_err(o_free_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst = 1'b1; reach_thrh = 1'b0; i_fea_addr = '0; i_r_fea_addr = '0;
        i_disp_rdy = '0; i_free = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse(input logic [11:0] a, input logic [11:0] ra);
        reach_thrh = 1'b1; i_fea_addr = a; i_r_fea_addr = ra;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++; if (o_disp_v !== 2'b00) begin errors++; $display("FAIL reset_disp_v: got %b want 00", o_disp_v); end
        checks++; if (o_disp_addr !== 12'h000) begin errors++; $display("FAIL reset_disp_addr: got %h want 000", o_disp_addr); end
        checks++; if (o_fifo_cnt !== 5'd0) begin errors++; $display("FAIL reset_fifo_cnt: got %0d want 0", o_fifo_cnt); end
        checks++; if (o_drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_drop_cnt: got %0d want 0", o_drop_cnt); end
        checks++; if ({o_free_v, o_free_err} !== 2'b00) begin errors++; $display("FAIL reset_free: got v=%b err=%b want 0 0", o_free_v, o_free_err); end
    endtask

    task automatic test_dispatch_rr();
        logic [1:0]  exp_v [1:7];
        logic [11:0] exp_a [1:7];
        exp_v = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
        exp_a = '{12'h0, 12'h010, 12'h0, 12'h011, 12'h0, 12'h012, 12'h0};
        do_reset();
        i_disp_rdy = 2'b11;
        pulse(12'h010, 12'h110);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            checks++; if (o_disp_v !== exp_v[c]) begin errors++; $display("FAIL rr_disp_v[%0d]: got %b want %b", c, o_disp_v, exp_v[c]); end
            if (exp_v[c] != 2'b00) begin
                checks++; if (o_disp_addr !== exp_a[c]) begin errors++; $display("FAIL rr_disp_addr[%0d]: got %h want %h", c, o_disp_addr, exp_a[c]); end
            end
            if (c == 1) pulse(12'h011, 12'h111);
            else if (c == 2) pulse(12'h012, 12'h112);
            else reach_thrh = 1'b0;
        end
        checks++; if (o_fifo_cnt !== 5'd0) begin errors++; $display("FAIL rr_fifo_cnt: got %0d want 0", o_fifo_cnt); end
    endtask

    task automatic test_backpressure();
        do_reset();
        i_disp_rdy = 2'b10;
        pulse(12'h0A5, 12'h1A5);
        @(negedge clk);
        reach_thrh = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            checks++; if (o_disp_v !== 2'b01 || o_disp_addr !== 12'h0A5) begin errors++; $display("FAIL hold[%0d]: got v=%b addr=%h want 01 0a5", c, o_disp_v, o_disp_addr); end
            checks++; if (o_fifo_cnt !== 5'd1) begin errors++; $display("FAIL hold_cnt[%0d]: got %0d want 1", c, o_fifo_cnt); end
            if (c == 4) i_disp_rdy = 2'b01;
            @(negedge clk);
        end
        checks++; if (o_disp_v !== 2'b00 || o_fifo_cnt !== 5'd0) begin errors++; $display("FAIL hold_release: got v=%b cnt=%0d want 00 0", o_disp_v, o_fifo_cnt); end
        checks++; if (o_disp_addr !== 12'h0A5) begin errors++; $display("FAIL hold_addr_keep: got %h want 0a5", o_disp_addr); end
        i_disp_rdy = 2'b00;
    endtask

    task automatic test_credit_limit();
        int n = 0;
        logic [1:0]  ev;
        logic [11:0] ea;
        do_reset();
        i_disp_rdy = 2'b11;
        pulse(12'h100, 12'h200);
        for (int c = 1; c <= 22; c++) begin
            @(negedge clk);
            if (o_disp_v != 2'b00) begin
                ev = (n % 2 == 0) ? 2'b01 : 2'b10;
                ea = 12'h100 + 12'(n);
                checks++; if (n >= 8 || o_disp_v !== ev || o_disp_addr !== ea) begin errors++; $display("FAIL credit_offer[%0d]: got v=%b addr=%h want v=%b addr=%h", n, o_disp_v, o_disp_addr, ev, ea); end
                n++;
            end
            if (c <= 9) pulse(12'h100 + 12'(c), 12'h200 + 12'(c));
            else reach_thrh = 1'b0;
        end
        checks++; if (n !== 8) begin errors++; $display("FAIL credit_offer_count: got %0d want 8", n); end
        checks++; if (o_fifo_cnt !== 5'd2 || o_disp_v !== 2'b00) begin errors++; $display("FAIL credit_stall: got cnt=%0d v=%b want 2 00", o_fifo_cnt, o_disp_v); end
        i_free = 2'b10;
        @(negedge clk);
        i_free = 2'b00;
        checks++; if (o_free_v !== 1'b0 || o_disp_v !== 2'b00) begin errors++; $display("FAIL credit_f1: got free_v=%b v=%b want 0 00", o_free_v, o_disp_v); end
        @(negedge clk);
        checks++; if (o_free_v !== 1'b1 || o_free_addr !== 12'h101 || o_free_r_addr !== 12'h201) begin errors++; $display("FAIL credit_f2: got v=%b %h/%h want 1 101/201", o_free_v, o_free_addr, o_free_r_addr); end
        checks++; if (o_disp_v !== 2'b00) begin errors++; $display("FAIL credit_f2_nooffer: got %b want 00", o_disp_v); end
        @(negedge clk);
        checks++; if (o_disp_v !== 2'b10 || o_disp_addr !== 12'h108 || o_free_v !== 1'b0) begin errors++; $display("FAIL credit_reoffer: got v=%b addr=%h fv=%b want 10 108 0", o_disp_v, o_disp_addr, o_free_v); end
    endtask

    task automatic test_queue_full();
        do_reset();
        i_disp_rdy = 2'b00;
        pulse(12'h300, 12'h400);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c <= 19) pulse(12'h300 + 12'(c), 12'h400 + 12'(c));
            else reach_thrh = 1'b0;
        end
        checks++; if (o_fifo_cnt !== 5'd16) begin errors++; $display("FAIL full_cnt: got %0d want 16", o_fifo_cnt); end
        checks++; if (o_drop_cnt !== 16'd4) begin errors++; $display("FAIL full_drop: got %0d want 4", o_drop_cnt); end
        checks++; if (o_disp_v !== 2'b01 || o_disp_addr !== 12'h300) begin errors++; $display("FAIL full_offer: got v=%b addr=%h want 01 300", o_disp_v, o_disp_addr); end
        i_disp_rdy = 2'b01;
        pulse(12'h3FF, 12'h4FF);
        @(negedge clk);
        reach_thrh = 1'b0; i_disp_rdy = 2'b00;
        checks++; if (o_fifo_cnt !== 5'd15 || o_drop_cnt !== 16'd5) begin errors++; $display("FAIL full_pushpop: got cnt=%0d drop=%0d want 15 5", o_fifo_cnt, o_drop_cnt); end
    endtask

    task automatic test_free_order();
        do_reset();
        i_disp_rdy = 2'b11;
        pulse(12'h020, 12'h120);
        @(negedge clk);
        pulse(12'h030, 12'h130);
        @(negedge clk);
        reach_thrh = 1'b0;
        repeat (5) @(negedge clk);
        i_free = 2'b11;
        @(negedge clk);
        i_free = 2'b00;
        checks++; if (o_free_v !== 1'b0) begin errors++; $display("FAIL order_f1: got free_v=%b want 0", o_free_v); end
        @(negedge clk);
        checks++; if (o_free_v !== 1'b1 || o_free_addr !== 12'h020 || o_free_r_addr !== 12'h120) begin errors++; $display("FAIL order_first: got v=%b %h/%h want 1 020/120", o_free_v, o_free_addr, o_free_r_addr); end
        @(negedge clk);
        checks++; if (o_free_v !== 1'b1 || o_free_addr !== 12'h030 || o_free_r_addr !== 12'h130) begin errors++; $display("FAIL order_second: got v=%b %h/%h want 1 030/130", o_free_v, o_free_addr, o_free_r_addr); end
        @(negedge clk);
        checks++; if (o_free_v !== 1'b0 || o_free_err !== 1'b0) begin errors++; $display("FAIL order_done: got v=%b err=%b want 0 0", o_free_v, o_free_err); end
    endtask

    task automatic test_free_err_reset();
        do_reset();
        i_free = 2'b01;
        @(negedge clk);
        i_free = 2'b00;
        checks++; if (o_free_err !== 1'b1 || o_free_v !== 1'b0) begin errors++; $display("FAIL err_set: got err=%b v=%b want 1 0", o_free_err, o_free_v); end
        @(negedge clk);
        checks++; if (o_free_err !== 1'b1 || o_free_v !== 1'b0) begin errors++; $display("FAIL err_sticky: got err=%b v=%b want 1 0", o_free_err, o_free_v); end
        i_disp_rdy = 2'b00;
        pulse(12'h055, 12'h155);
        @(negedge clk);
        reach_thrh = 1'b0;
        @(negedge clk);
        checks++; if (o_disp_v !== 2'b01 || o_disp_addr !== 12'h055) begin errors++; $display("FAIL err_offer: got v=%b addr=%h want 01 055", o_disp_v, o_disp_addr); end
        #2 rst = 1'b1;
        #1;
        checks++; if (o_disp_v !== 2'b00 || o_disp_addr !== 12'h000) begin errors++; $display("FAIL midrst_disp: got v=%b addr=%h want 00 000", o_disp_v, o_disp_addr); end
        checks++; if (o_fifo_cnt !== 5'd0 || o_free_err !== 1'b0 || o_free_v !== 1'b0) begin errors++; $display("FAIL midrst_state: got cnt=%0d err=%b fv=%b want 0 0 0", o_fifo_cnt, o_free_err, o_free_v); end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (o_disp_v !== 2'b00 || o_free_v !== 1'b0) begin errors++; $display("FAIL postrst_idle: got v=%b fv=%b want 00 0", o_disp_v, o_free_v); end
    endtask

    initial begin
        test_reset();
        test_dispatch_rr();
        test_backpressure();
        test_credit_limit();
        test_queue_full();
        test_free_order();
        test_free_err_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
